rv32i_yurut: RTL and testbench

RV32I execute stage: the consumer of the decoder's `a_op`/`a_rd`/`a_in1..3` bundle. It accepts one decoded instruction per handshake and performs ALU, compare, shift, branch/jump, LUI/AUIPC and load/store work. It drives register writeback, branch redirect and a single-port data-memory request interface. It sits between the decode stage and the register file / fetch PC mux.

---
 rtl/rv32i_yurut.sv | 214 +++++++++++++++++++++
 tb/tb_rv32i_yurut.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_yurut.sv
// RV32I execute stage: ALU, compare, shifts, branches/jumps, LUI/AUIPC and load/store.
// Accepts one decoded instruction per handshake; all pulse and data outputs are registered.
module rv32i_yurut #(
  parameter int unsigned SHIFT_SERIAL = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  a_op,
  input  logic [4:0]  a_rd,
  input  logic [31:0] a_in1,
  input  logic [31:0] a_in2,
  input  logic [31:0] a_in3,
  input  logic [31:0] a_pc,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        br_valid,
  output logic [31:0] br_target,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        err
);

  typedef enum logic [1:0] {StIdle, StShift, StMem} state_e;

  state_e      state;
  logic [31:0] sh_val;
  logic [4:0]  sh_cnt;
  logic [4:0]  rd_q;
  logic        sh_left;
  logic        sh_arith;
  logic [2:0]  ld_f;
  logic [1:0]  ld_off;

  logic [2:0]  f;
  logic [4:0]  shamt;
  logic [31:0] sum, diff, ea, alu_res, wb_val, ld_lane, ld_val, sh_next;
  logic        lt, ltu, taken, misal, serial;
  logic        is_alu, is_br, is_load, is_store, is_wbop, is_jump;

  assign in_ready = (state == StIdle);
  assign f        = a_op[2:0];
  assign shamt    = a_in2[4:0];

  always_comb begin
    sum  = a_in1 + a_in2;
    diff = a_in1 - a_in2;
    ea   = a_op[3] ? (a_in1 + a_in3) : sum;
    lt   = $signed(a_in1) < $signed(a_in2);
    ltu  = a_in1 < a_in2;

    unique case (f)
      3'b000:  alu_res = sum;
      3'b001:  alu_res = a_in1 << shamt;
      3'b010:  alu_res = {31'd0, lt};
      3'b011:  alu_res = {31'd0, ltu};
      3'b100:  alu_res = a_in1 ^ a_in2;
      3'b101:  alu_res = a_in2[5] ? $unsigned($signed(a_in1) >>> shamt) : (a_in1 >> shamt);
      3'b110:  alu_res = a_in1 | a_in2;
      default: alu_res = a_in1 & a_in2;
    endcase

    is_alu   = (a_op[4:3] == 2'b00);
    is_br    = (a_op[4:3] == 2'b01) && (f[2:1] != 2'b01);
    is_load  = (a_op[4:3] == 2'b10) && (f != 3'b011) && (f[2:1] != 2'b11);
    is_store = (a_op[4:3] == 2'b11) && !f[2] && (f != 3'b011);
    is_jump  = (a_op[4:1] == 4'b1111);
    is_wbop  = is_alu || (a_op[4:1] == 4'b0101) || (a_op[4:2] == 3'b111);
    serial   = (SHIFT_SERIAL != 0) && is_alu && (f[1:0] == 2'b01) && (shamt != 5'd0);

    case (f[1:0])
      2'b01:   misal = ea[0];
      2'b10:   misal = |ea[1:0];
      default: misal = 1'b0;
    endcase

    case (f)
      3'b000:  taken = (a_in1 == a_in2);
      3'b001:  taken = (a_in1 != a_in2);
      3'b100:  taken = lt;
      3'b101:  taken = !lt;
      3'b110:  taken = ltu;
      3'b111:  taken = !ltu;
      default: taken = 1'b0;
    endcase

    if (is_alu) begin
      wb_val = alu_res;
    end else begin
      case (a_op)
        5'b01010: wb_val = diff;
        5'b01011: wb_val = sum;
        5'b11100: wb_val = a_in1;
        5'b11101: wb_val = a_pc + a_in1;
        default:  wb_val = a_pc + 32'd4;
      endcase
    end

    sh_next = sh_left ? (sh_val << 1) : {sh_arith & sh_val[31], sh_val[31:1]};

    // Load lane: move the addressed byte/half down to bit 0, then extend.
    ld_lane = mem_rdata >> {ld_off, 3'b000};
    case (ld_f)
      3'b000:  ld_val = {{24{ld_lane[7]}}, ld_lane[7:0]};
      3'b001:  ld_val = {{16{ld_lane[15]}}, ld_lane[15:0]};
      3'b100:  ld_val = {24'd0, ld_lane[7:0]};
      3'b101:  ld_val = {16'd0, ld_lane[15:0]};
      default: ld_val = mem_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= StIdle;
      wb_valid  <= 1'b0;
      wb_rd     <= 5'd0;
      wb_data   <= 32'd0;
      br_valid  <= 1'b0;
      br_target <= 32'd0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'd0;
      mem_wdata <= 32'd0;
      mem_be    <= 4'd0;
      err       <= 1'b0;
      sh_val    <= 32'd0;
      sh_cnt    <= 5'd0;
      rd_q      <= 5'd0;
      sh_left   <= 1'b0;
      sh_arith  <= 1'b0;
      ld_f      <= 3'd0;
      ld_off    <= 2'd0;
    end else begin
      wb_valid <= 1'b0;
      br_valid <= 1'b0;
      err      <= 1'b0;
      unique case (state)
        StIdle: begin
          if (in_valid) begin
            if (serial) begin
              state    <= StShift;
              sh_val   <= a_in1;
              sh_cnt   <= shamt;
              sh_left  <= !f[2];
              sh_arith <= a_in2[5];
              rd_q     <= a_rd;
            end else if (is_load || is_store) begin
              if (misal) begin
                err <= 1'b1;
              end else begin
                state     <= StMem;
                mem_req   <= 1'b1;
                mem_we    <= is_store;
                mem_addr  <= {ea[31:2], 2'b00};
                mem_be    <= (f[1:0] == 2'b00) ? (4'b0001 << ea[1:0]) :
                             (f[1:0] == 2'b01) ? (ea[1] ? 4'b1100 : 4'b0011) : 4'b1111;
                mem_wdata <= (f[1:0] == 2'b00) ? {4{a_in2[7:0]}} :
                             (f[1:0] == 2'b01) ? {2{a_in2[15:0]}} : a_in2;
                ld_f      <= f;
                ld_off    <= ea[1:0];
                rd_q      <= a_rd;
              end
            end else if (is_br) begin
              if (taken) begin
                br_valid  <= 1'b1;
                br_target <= a_pc + a_in3;
              end
            end else if (is_wbop) begin
              wb_valid <= (a_rd != 5'd0);
              wb_rd    <= a_rd;
              wb_data  <= wb_val;
              if (is_jump) begin
                br_valid  <= 1'b1;
                br_target <= f[0] ? (sum & ~32'd1) : (a_pc + a_in1);
              end
            end else begin
              err <= 1'b1;
            end
          end
        end
        StShift: begin
          sh_val <= sh_next;
          sh_cnt <= sh_cnt - 5'd1;
          if (sh_cnt == 5'd1) begin
            state    <= StIdle;
            wb_valid <= (rd_q != 5'd0);
            wb_rd    <= rd_q;
            wb_data  <= sh_next;
          end
        end
        StMem: begin
          if (mem_ack) begin
            state   <= StIdle;
            mem_req <= 1'b0;
            if (!mem_we) begin
              wb_valid <= (rd_q != 5'd0);
              wb_rd    <= rd_q;
              wb_data  <= ld_val;
            end
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_rv32i_yurut.sv
// Self-checking bench for rv32i_yurut: directed instructions, behavioural model,
// per-cycle comparison of the pulse outputs and memory request.
module tb_rv32i_yurut;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [4:0]  a_op, a_rd;
  logic [31:0] a_in1, a_in2, a_in3, a_pc;
  logic        wb_valid, br_valid, mem_req, mem_we, mem_ack, err;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data, br_target, mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  rv32i_yurut dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a_op(a_op), .a_rd(a_rd), .a_in1(a_in1), .a_in2(a_in2), .a_in3(a_in3), .a_pc(a_pc),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .br_valid(br_valid), .br_target(br_target),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          wb, br, er, mem, we;
    logic [4:0]  rd;
    logic [2:0]  f;
    logic [31:0] data, tgt, addr, wdata, ea;
    logic [3:0]  be;
    int          lat;
  } exp_t;

  int nchk = 0;
  int nerr = 0;
  int ncyc = 0;
  bit mem_expect = 0;
  bit          exp_wb [int];
  logic [4:0]  exp_rd [int];
  logic [31:0] exp_data [int];
  bit          exp_br [int];
  logic [31:0] exp_tgt [int];
  bit          exp_err [int];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    nchk++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic exp_t model(input logic [4:0] op, input logic [4:0] rd,
                                 input logic [31:0] i1, input logic [31:0] i2,
                                 input logic [31:0] i3, input logic [31:0] pc);
    exp_t e;
    logic [2:0] f;
    logic [31:0] v, ea;
    bit wbop, t;
    int nb;
    e = '{default: 0};
    f = op[2:0];
    v = 0;
    wbop = 0;
    t = 0;
    if (op[4:3] == 2'b00) begin
      wbop = 1;
      case (f)
        3'd0: v = i1 + i2;
        3'd1: v = i1 << i2[4:0];
        3'd2: v = ($signed(i1) < $signed(i2)) ? 1 : 0;
        3'd3: v = (i1 < i2) ? 1 : 0;
        3'd4: v = i1 ^ i2;
        3'd5: v = i2[5] ? $unsigned($signed(i1) >>> i2[4:0]) : (i1 >> i2[4:0]);
        3'd6: v = i1 | i2;
        default: v = i1 & i2;
      endcase
      if (f == 3'd1 || f == 3'd5) e.lat = int'(i2[4:0]);
    end else if (op == 5'b01010) begin
      wbop = 1; v = i1 - i2;
    end else if (op == 5'b01011) begin
      wbop = 1; v = i1 + i2;
    end else if (op[4:3] == 2'b01) begin
      case (f)
        3'd0: t = (i1 == i2);
        3'd1: t = (i1 != i2);
        3'd4: t = ($signed(i1) < $signed(i2));
        3'd5: t = ($signed(i1) >= $signed(i2));
        3'd6: t = (i1 < i2);
        default: t = (i1 >= i2);
      endcase
      e.br = t;
      e.tgt = pc + i3;
    end else if (op[4:3] == 2'b11 && f[2]) begin
      wbop = 1;
      case (f)
        3'd4: v = i1;
        3'd5: v = pc + i1;
        3'd6: begin v = pc + 4; e.br = 1; e.tgt = pc + i1; end
        default: begin v = pc + 4; e.br = 1; e.tgt = (i1 + i2) & 32'hFFFF_FFFE; end
      endcase
    end else if (f == 3'd3 || f[2:1] == 2'b11) begin
      e.er = 1;
    end else begin
      nb = 1 << f[1:0];
      ea = op[3] ? i1 + i3 : i1 + i2;
      if ((ea[1:0] & 2'(nb - 1)) != 2'd0) begin
        e.er = 1;
      end else begin
        e.mem = 1;
        e.we = op[3];
        e.addr = ea & 32'hFFFF_FFFC;
        e.be = 4'(((1 << nb) - 1) << ea[1:0]);
        e.wdata = (nb == 1) ? {4{i2[7:0]}} : (nb == 2) ? {2{i2[15:0]}} : i2;
        e.ea = ea;
        e.f = f;
      end
    end
    e.rd = rd;
    e.data = v;
    e.wb = wbop && (rd != 5'd0);
    return e;
  endfunction

  function automatic logic [31:0] ldres(input logic [2:0] f, input logic [31:0] ea,
                                        input logic [31:0] rdata);
    logic [31:0] v;
    v = rdata >> (8 * ea[1:0]);
    if (f[1:0] == 2'd0) v = f[2] ? {24'd0, v[7:0]} : {{24{v[7]}}, v[7:0]};
    else if (f[1:0] == 2'd1) v = f[2] ? {16'd0, v[15:0]} : {{16{v[15]}}, v[15:0]};
    return v;
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      ncyc = ncyc + 1;
      check("wb_valid", 32'(wb_valid), 32'(exp_wb.exists(ncyc)));
      if (exp_wb.exists(ncyc)) begin
        check("wb_rd", 32'(wb_rd), 32'(exp_rd[ncyc]));
        check("wb_data", wb_data, exp_data[ncyc]);
        exp_wb.delete(ncyc);
      end
      check("br_valid", 32'(br_valid), 32'(exp_br.exists(ncyc)));
      if (exp_br.exists(ncyc)) begin
        check("br_target", br_target, exp_tgt[ncyc]);
        exp_br.delete(ncyc);
      end
      check("err", 32'(err), 32'(exp_err.exists(ncyc)));
      if (exp_err.exists(ncyc)) exp_err.delete(ncyc);
      check("mem_req", 32'(mem_req), 32'(mem_expect));
    end
  end

  task automatic go(input logic [4:0] op, input logic [4:0] rd, input logic [31:0] i1,
                    input logic [31:0] i2, input logic [31:0] i3, input logic [31:0] pc,
                    input int waits, input logic [31:0] rdata);
    exp_t e;
    int k;
    e = model(op, rd, i1, i2, i3, pc);
    @(negedge clk); #1;
    check("in_ready", 32'(in_ready), 32'd1);
    a_op = op; a_rd = rd; a_in1 = i1; a_in2 = i2; a_in3 = i3; a_pc = pc;
    in_valid = 1'b1;
    k = ncyc + 1 + e.lat;
    if (e.wb) begin exp_wb[k] = 1; exp_rd[k] = e.rd; exp_data[k] = e.data; end
    if (e.br) begin exp_br[k] = 1; exp_tgt[k] = e.tgt; end
    if (e.er) exp_err[k] = 1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (e.lat) begin
      @(negedge clk); #1;
      check("in_ready_shift", 32'(in_ready), 32'd0);
    end
    if (e.mem) begin
      mem_expect = 1;
      for (int i = 0; i <= waits; i++) begin
        @(negedge clk); #1;
        check("mem_we", 32'(mem_we), 32'(e.we));
        check("mem_addr", mem_addr, e.addr);
        check("mem_be", 32'(mem_be), 32'(e.be));
        if (e.we) check("mem_wdata", mem_wdata, e.wdata);
      end
      mem_ack = 1'b1;
      mem_rdata = rdata;
      if (!e.we && e.rd != 5'd0) begin
        exp_wb[ncyc + 1] = 1;
        exp_rd[ncyc + 1] = e.rd;
        exp_data[ncyc + 1] = ldres(e.f, e.ea, rdata);
      end
      @(posedge clk); #1;
      mem_ack = 1'b0;
      mem_rdata = 32'h5A5A_5A5A;
      mem_expect = 0;
    end
  endtask

  initial begin
    exp_t e;
    rst = 1'b1; in_valid = 1'b0; mem_ack = 1'b0; mem_rdata = 32'd0;
    a_op = 5'd0; a_rd = 5'd0; a_in1 = 32'd0; a_in2 = 32'd0; a_in3 = 32'd0; a_pc = 32'd0;

    // Hand-computed values pinning the model.
    e = model(5'b00000, 5'd5, 32'hFFFF_FFFF, 32'd2, 32'd0, 32'd0);
    check("pin_addi", e.data, 32'h0000_0001);
    e = model(5'b00101, 5'd10, 32'h8000_0000, 32'h24, 32'd0, 32'd0);
    check("pin_srai", e.data, 32'hF800_0000);
    check("pin_srai_lat", e.lat, 4);
    e = model(5'b01100, 5'd0, 32'hFFFF_FFFE, 32'd1, 32'h10, 32'h100);
    check("pin_blt", e.tgt, 32'h110);
    check("pin_lh", ldres(3'b001, 32'h1002, 32'h8001_1234), 32'hFFFF_8001);
    e = model(5'b11000, 5'd0, 32'h2000, 32'hAB, 32'd3, 32'd0);
    check("pin_sb_be", 32'(e.be), 32'h8);
    check("pin_sb_wdata", e.wdata, 32'hABAB_ABAB);

    repeat (2) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_wb_valid", 32'(wb_valid), 32'd0);
    check("rst_br_valid", 32'(br_valid), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_wb_data", wb_data, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    #1 rst = 1'b0;

    go(5'b00000, 5'd5, 32'hFFFF_FFFF, 32'd2, 0, 0, 0, 0);
    go(5'b01010, 5'd6, 32'h10, 32'd3, 0, 0, 0, 0);
    go(5'b00100, 5'd7, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 0, 0, 0, 0);
    go(5'b00110, 5'd7, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 0, 0, 0, 0);
    go(5'b00111, 5'd7, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 0, 0, 0, 0);
    go(5'b00010, 5'd8, 32'hFFFF_FFFF, 32'd1, 0, 0, 0, 0);
    go(5'b00011, 5'd8, 32'hFFFF_FFFF, 32'd1, 0, 0, 0, 0);
    go(5'b00001, 5'd9, 32'h1, 32'd3, 0, 0, 0, 0);
    go(5'b00101, 5'd10, 32'h8000_0000, 32'h24, 0, 0, 0, 0);
    go(5'b00101, 5'd10, 32'h8000_0000, 32'h4, 0, 0, 0, 0);
    go(5'b00101, 5'd11, 32'h1234_5678, 32'h0, 0, 0, 0, 0);
    go(5'b00001, 5'd11, 32'h1234_5678, 32'h20, 0, 0, 0, 0);
    go(5'b01011, 5'd0, 32'd1, 32'd2, 0, 0, 0, 0);
    go(5'b01100, 5'd0, 32'hFFFF_FFFE, 32'd1, 32'h10, 32'h100, 0, 0);
    go(5'b01110, 5'd0, 32'hFFFF_FFFE, 32'd1, 32'h10, 32'h100, 0, 0);
    go(5'b01000, 5'd0, 32'd5, 32'd5, 32'hFFFF_FFF8, 32'h200, 0, 0);
    go(5'b01001, 5'd0, 32'd5, 32'd5, 32'h40, 32'h200, 0, 0);
    go(5'b01101, 5'd0, 32'd1, 32'hFFFF_FFFE, 32'h8, 32'h300, 0, 0);
    go(5'b01111, 5'd0, 32'd1, 32'hFFFF_FFFE, 32'h8, 32'h300, 0, 0);
    go(5'b11100, 5'd1, 32'h1234_5000, 0, 0, 0, 0, 0);
    go(5'b11101, 5'd2, 32'h1000, 0, 0, 32'h400, 0, 0);
    go(5'b11110, 5'd1, 32'h20, 0, 0, 32'h300, 0, 0);
    go(5'b11111, 5'd0, 32'h201, 32'd0, 0, 32'h500, 0, 0);
    go(5'b10001, 5'd3, 32'h1000, 32'd2, 0, 0, 3, 32'h8001_1234);
    go(5'b10001, 5'd3, 32'h1000, 32'd3, 0, 0, 0, 0);
    go(5'b10010, 5'd4, 32'h1000, 32'd4, 0, 0, 0, 32'hDEAD_BEEF);
    go(5'b10100, 5'd5, 32'h1000, 32'd1, 0, 0, 1, 32'h0000_8000);
    go(5'b10000, 5'd5, 32'h1003, 32'd0, 0, 0, 2, 32'h80FF_0000);
    go(5'b10101, 5'd6, 32'h1000, 32'd2, 0, 0, 1, 32'h8001_1234);
    go(5'b10010, 5'd4, 32'h1002, 32'd0, 0, 0, 0, 0);
    go(5'b11000, 5'd9, 32'h2000, 32'hAB, 32'd3, 0, 1, 0);
    go(5'b11001, 5'd0, 32'h2000, 32'h1234_BEEF, 32'd2, 0, 0, 0);
    go(5'b11010, 5'd0, 32'h2004, 32'hCAFE_F00D, 32'd0, 0, 2, 0);
    go(5'b11001, 5'd0, 32'h2000, 32'h1234_BEEF, 32'd1, 0, 0, 0);
    go(5'b10011, 5'd1, 32'd1, 32'd1, 0, 0, 0, 0);
    go(5'b11011, 5'd1, 32'd1, 32'd1, 0, 0, 0, 0);
    go(5'b10110, 5'd1, 32'd1, 32'd1, 0, 0, 0, 0);

    // Reset while waiting on a load: request drops at once, no writeback follows.
    @(negedge clk); #1;
    a_op = 5'b10010; a_rd = 5'd7; a_in1 = 32'h3000; a_in2 = 32'd0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    mem_expect = 1;
    @(negedge clk); #1;
    check("mem_req_pre_rst", 32'(mem_req), 32'd1);
    rst = 1'b1;
    #1;
    check("rst_mid_mem_req", 32'(mem_req), 32'd0);
    check("rst_mid_in_ready", 32'(in_ready), 32'd1);
    check("rst_mid_wb_valid", 32'(wb_valid), 32'd0);
    mem_expect = 0;
    @(negedge clk); #1;
    rst = 1'b0;
    mem_ack = 1'b1;
    @(negedge clk); #1;
    mem_ack = 1'b0;
    go(5'b00000, 5'd12, 32'd40, 32'd2, 0, 0, 0, 0);

    repeat (3) @(negedge clk);
    #1;
    check("pending", exp_wb.num() + exp_br.num() + exp_err.num(), 0);
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
